// File: rtl/ring_drain_packetizer.sv
// Drains a ring buffer into valid/ready packets with a last flag. A one-word stage register
// holds the newest word until it is known whether that word closes its packet.
module ring_drain_packetizer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PKT_LEN = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_deq,
    input  logic             flush_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_last_o,
    output logic [15:0]      pkt_cnt_o
);

    localparam int unsigned BeatW = $clog2(PKT_LEN + 1);
    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

    localparam logic [BeatW-1:0] BeatOne = BeatW'(1);
    localparam logic [BeatW-1:0] BeatMax = BeatW'(PKT_LEN);
    localparam logic [IdleW-1:0] IdleOne = IdleW'(1);
    localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT);

    typedef enum logic {
        StEmpty = 1'b0,
        StHold  = 1'b1
    } state_e;

    state_e           state;
    logic [WIDTH-1:0] s_dat;
    logic [BeatW-1:0] s_beat;
    logic [IdleW-1:0] idle;

    logic s_vld;
    logic o_free;
    logic fin;
    logic close;
    logic move;
    logic pkt_done;

    always_comb begin
        s_vld    = (state == StHold);
        o_free   = ~m_valid_o | m_ready_i;
        fin      = (s_beat == BeatMax);
        close    = fifo_empty & (flush_i | (idle == IdleMax));
        move     = s_vld & o_free & (~fifo_empty | fin | close);
        // A full stage word at its final beat must leave before another word may enter.
        fifo_deq = ~rst & ~fifo_empty & (~s_vld | (o_free & (move | ~fin)));
        pkt_done = m_valid_o & m_ready_i & m_last_o;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StEmpty;
            s_dat     <= '0;
            s_beat    <= BeatOne;
            idle      <= '0;
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
            m_last_o  <= 1'b0;
            pkt_cnt_o <= '0;
        end else begin
            // Output register: load from stage, or retire the accepted word.
            if (move) begin
                m_data_o  <= s_dat;
                m_valid_o <= 1'b1;
                m_last_o  <= fin | close;
            end else if (m_ready_i) begin
                m_valid_o <= 1'b0;
            end

            unique case (state)
                StEmpty: begin
                    if (fifo_deq) begin
                        state  <= StHold;
                        s_dat  <= fifo_data;
                        s_beat <= BeatOne;
                    end
                end
                StHold: begin
                    if (fifo_deq) begin
                        s_dat  <= fifo_data;
                        s_beat <= (move && (fin || close)) ? BeatOne : s_beat + BeatOne;
                    end else if (move) begin
                        state <= StEmpty;
                    end
                end
                default: state <= StEmpty;
            endcase

            if (fifo_deq || move || !s_vld) begin
                idle <= '0;
            end else if (fifo_empty && (idle != IdleMax)) begin
                idle <= idle + IdleOne;
            end

            if (pkt_done) begin
                pkt_cnt_o <= pkt_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ring_drain_packetizer.sv
// Bench for ring_drain_packetizer: a ring-buffer model feeds the DUT and a scoreboard
// checks every accepted beat, plus timing, stall, flush and reset corner cases.
module tb_ring_drain_packetizer;

    localparam int WIDTH   = 8;
    localparam int PKT_LEN = 4;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_deq;
    logic             flush_i = 1'b0;
    logic             m_valid_o;
    logic             m_ready_i = 1'b1;
    logic [WIDTH-1:0] m_data_o;
    logic             m_last_o;
    logic [15:0]      pkt_cnt_o;

    ring_drain_packetizer #(
        .WIDTH  (WIDTH),
        .PKT_LEN(PKT_LEN),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_deq  (fifo_deq),
        .flush_i   (flush_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_o),
        .m_last_o  (m_last_o),
        .pkt_cnt_o (pkt_cnt_o)
    );

    always #5 clk = ~clk;

    // Ring buffer model
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_data  = mem[rd_ptr];
    always @(posedge clk) if (fifo_deq) rd_ptr <= rd_ptr + 8'd1;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       rand_ready;
    } vec_t;

    beat_t exp_q[$];
    int    deq_cyc_q[$];
    beat_t mon_e;
    int    cyc = 0;
    int    last_lat = -1;
    int    exp_pkt = 0;
    int    n_vec = 0;
    int    n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor samples at negedge: inputs change just after posedge, so values here are final.
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_deq) deq_cyc_q.push_back(cyc);
            if (m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got data %0h last %0b, want no beat",
                             m_data_o, m_last_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat", {23'd0, m_data_o, m_last_o}, {23'd0, mon_e.data, mon_e.last});
                    if (mon_e.last) exp_pkt++;
                end
                if (deq_cyc_q.size() > 0) last_lat = cyc - deq_cyc_q.pop_front();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic last);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 8'd1;
        exp_q.push_back({d, last});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_drain: %0d beats outstanding, want 0", name, exp_q.size());
        end
        tick();
        tick();
        check({name, "_pkt_cnt"}, pkt_cnt_o, exp_pkt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl[14];
        int   n;

        for (int i = 0; i < 8; i++) begin
            tbl[i].data       = 8'h10 + 8'(i);
            tbl[i].last       = (i == 3) || (i == 7);
            tbl[i].rand_ready = 1'b0;
        end
        // Second group closes once on beat 4, then by timeout on beat 2.
        for (int i = 8; i < 14; i++) begin
            tbl[i].data       = 8'h40 + 8'(i);
            tbl[i].last       = (i == 11) || (i == 13);
            tbl[i].rand_ready = 1'b1;
        end

        // Reset state, with words already waiting in the buffer
        for (int i = 0; i < 8; i++) push(tbl[i].data, tbl[i].last);
        #1;
        check("rst_valid", m_valid_o, 0);
        check("rst_data", m_data_o, 0);
        check("rst_last", m_last_o, 0);
        check("rst_pkt_cnt", pkt_cnt_o, 0);
        check("rst_deq", fifo_deq, 0);
        tick();
        check("rst_deq_hold", fifo_deq, 0);

        // Preloaded burst: dequeue on 8 consecutive cycles
        rst = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            check("deq_burst", fifo_deq, 1);
            tick();
        end
        check("deq_burst_end", fifo_deq, 0);
        drain("burst");
        check("stream_lat", last_lat, 2);

        // Random backpressure
        for (int i = 8; i < 14; i++) push(tbl[i].data, tbl[i].last);
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            m_ready_i = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        m_ready_i = 1'b1;
        drain("rand");

        // 10-cycle stall mid-stream
        for (int i = 0; i < 8; i++) push(8'h60 + 8'(i), (i == 3) || (i == 7));
        tick();
        tick();
        tick();
        m_ready_i = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) begin
            check("stall_valid", m_valid_o, 1);
            check("stall_data", m_data_o, exp_q[0].data);
            check("stall_last", m_last_o, exp_q[0].last);
            check("stall_deq", fifo_deq, 0);
            tick();
        end
        m_ready_i = 1'b1;
        drain("stall");

        // Timeout closes a 3-word packet
        push(8'h70, 1'b0);
        push(8'h71, 1'b0);
        push(8'h72, 1'b1);
        drain("timeout");
        check("timeout_lat", last_lat, TIMEOUT + 2);

        // Flush closes a mid-packet word; flush with an empty stage does nothing
        push(8'h80, 1'b0);
        push(8'h81, 1'b1);
        tick();
        tick();
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drain("flush");
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        check("flush_empty_valid", m_valid_o, 0);
        for (int i = 0; i < 4; i++) push(8'h90 + 8'(i), i == 3);
        drain("after_flush");

        // Word arriving exactly when idle reaches TIMEOUT joins the packet
        push(8'hA0, 1'b0);
        for (int i = 0; i < TIMEOUT + 1; i++) tick();
        check("no_early_close", m_valid_o, 0);
        push(8'hA1, 1'b0);
        push(8'hA2, 1'b0);
        push(8'hA3, 1'b1);
        drain("edge_timeout");

        // Reset mid-packet: O and S hold words, one more waits in the buffer
        m_ready_i = 1'b0;
        push(8'hB0, 1'b0);
        push(8'hB1, 1'b0);
        push(8'hB2, 1'b0);
        tick();
        tick();
        tick();
        check("pre_rst_valid", m_valid_o, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", m_valid_o, 0);
        check("mid_rst_data", m_data_o, 0);
        check("mid_rst_last", m_last_o, 0);
        check("mid_rst_deq", fifo_deq, 0);
        check("mid_rst_pkt_cnt", pkt_cnt_o, 0);
        exp_q.delete();
        deq_cyc_q.delete();
        exp_pkt = 0;
        exp_q.push_back({8'hB2, 1'b0});
        tick();
        rst = 1'b0;
        m_ready_i = 1'b1;
        push(8'hB3, 1'b0);
        push(8'hB4, 1'b0);
        push(8'hB5, 1'b1);
        drain("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
